logic_unit_arbiter: RTL

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter feeding a bitwise logic unit; IDLE -> EXEC -> RESP,
// result registered two edges after presentation, held until consumer handshake.
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             last;
    logic             gnt_vld;
    logic             gnt_id;
    logic [WIDTH-1:0] res;
    logic             res_err;

    // On a tie the requester not served last wins; last resets to 1 so req0 wins first.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = (req0_valid & req1_valid) ? ~last : req1_valid;
    end

    assign req0_ready = ~rst && (state == IDLE) && gnt_vld && !gnt_id;
    assign req1_ready = ~rst && (state == IDLE) && gnt_vld && gnt_id;

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (op_q)
            4'd0:    res = a_q & b_q;
            4'd1:    res = a_q | b_q;
            4'd2:    res = ~a_q;
            4'd3:    res = ~(a_q & b_q);
            4'd4:    res = ~(a_q | b_q);
            4'd5:    res = a_q ^ b_q;
            4'd6:    res = ~(a_q ^ b_q);
            4'd7:    res = a_q;
            4'd8:    res = b_q;
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            last      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        op_q  <= gnt_id ? req1_op : req0_op;
                        a_q   <= gnt_id ? req1_a  : req0_a;
                        b_q   <= gnt_id ? req1_b  : req0_b;
                        id_q  <= gnt_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= res;
                    rsp_err   <= res_err;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last      <= rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
